uop_window_ctrl: RTL

- Collects retired uops from NRET commit ports into a FIFO.
- Serializes them one per cycle into a three-slot window of last / this / next cycle (lc/tc/nc) that feeds the instruction-type detector.
- Sequences the window through fill, run and drain, so tc is presented only when its successor (nc) is known or the stream has ended.
- Applies backpressure to commit and handles flush.

---
 rtl/mure_pkg.sv | 20 ++
 rtl/uop_compact_fifo.sv | 69 ++++++
 rtl/uop_window_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared uop types and window-controller constants for the MURE retire path.
package mure_pkg;

  localparam int unsigned UOP_NRET       = 2;
  localparam int unsigned UOP_FIFO_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } uop_entry_s;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } win_state_e;

endpackage

// File: rtl/uop_compact_fifo.sv
// Multi-write, single-read uop FIFO; valid write ports are packed into
// consecutive slots in port order.
module uop_compact_fifo
  import mure_pkg::*;
#(
  parameter int unsigned NRET  = UOP_NRET,
  parameter int unsigned DEPTH = UOP_FIFO_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  uop_entry_s [NRET-1:0]          wr_entry_i,
  input  logic                           pop_i,
  output uop_entry_s                     head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           ready_o,
  output logic                           nonempty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  uop_entry_s       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] push_cnt;
  logic [PTR_W-1:0] slot_idx [NRET];
  logic [NRET-1:0]  slot_we;

  // Each valid port lands at write pointer + number of valid ports before it.
  always_comb begin
    push_cnt = '0;
    for (int unsigned k = 0; k < NRET; k++) begin
      slot_idx[k] = wr_ptr_q + PTR_W'(push_cnt);
      slot_we[k]  = wr_en_i && wr_entry_i[k].valid;
      if (slot_we[k]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NRET; k++) begin
      if (slot_we[k]) mem_q[slot_idx[k]] <= wr_entry_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_cnt);
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_q + push_cnt - CNT_W'(pop_i);
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign nonempty_o = (count_q != '0);
  assign ready_o    = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NRET);

endmodule

// File: rtl/uop_window_ctrl.sv
// Serialises buffered retired uops into an lc/tc/nc window, presenting tc
// only once its successor is known or the stream has ended.
module uop_window_ctrl
  import mure_pkg::*;
#(
  parameter int unsigned NRET       = UOP_NRET,
  parameter int unsigned FIFO_DEPTH = UOP_FIFO_DEPTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  uop_entry_s [NRET-1:0]             uop_entry_i,
  output logic                              ready_o,
  input  logic                              end_i,
  input  logic                              flush_i,
  output uop_entry_s                        lc_uop_entry_o,
  output uop_entry_s                        tc_uop_entry_o,
  output uop_entry_s                        nc_uop_entry_o,
  output logic                              window_valid_o,
  input  logic                              window_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy_o,
  output logic                              overflow_o
);

  win_state_e state_q, state_d;
  uop_entry_s lc_q, tc_q, nc_q;
  uop_entry_s lc_d, tc_d, nc_d;
  uop_entry_s fifo_head;
  logic       fifo_nonempty;
  logic       fifo_ready;
  logic       any_valid;
  logic       shift_ok;
  logic       advance;
  logic       pop;
  logic       overflow_q;

  uop_compact_fifo #(
    .NRET  (NRET),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .wr_en_i    (fifo_ready && !flush_i),
    .wr_entry_i (uop_entry_i),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (occupancy_o),
    .ready_o    (fifo_ready),
    .nonempty_o (fifo_nonempty)
  );

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NRET; k++) begin
      any_valid = any_valid | uop_entry_i[k].valid;
    end
  end

  always_comb begin
    window_valid_o = 1'b0;
    unique case (state_q)
      RUN:     window_valid_o = tc_q.valid && nc_q.valid;
      DRAIN:   window_valid_o = tc_q.valid;
      default: window_valid_o = 1'b0;
    endcase
  end

  assign shift_ok = !window_valid_o || window_ready_i;
  assign advance  = !flush_i && shift_ok && (fifo_nonempty || state_q == DRAIN);
  assign pop      = advance && fifo_nonempty;

  always_comb begin
    lc_d    = lc_q;
    tc_d    = tc_q;
    nc_d    = nc_q;
    state_d = state_q;
    if (advance) begin
      lc_d = tc_q;
      tc_d = nc_q;
      nc_d = fifo_nonempty ? fifo_head : '0;
    end
    unique case (state_q)
      IDLE:  if (fifo_nonempty) state_d = FILL;
      // FILL promotes on the post-shift window contents.
      FILL:  if (end_i) state_d = DRAIN;
             else if (tc_d.valid && nc_d.valid) state_d = RUN;
      RUN:   if (end_i) state_d = DRAIN;
      DRAIN: if (!tc_q.valid && !nc_q.valid && !fifo_nonempty) begin
               state_d = IDLE;
               lc_d    = '0;
               tc_d    = '0;
               nc_d    = '0;
             end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      lc_d    = '0;
      tc_d    = '0;
      nc_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lc_q       <= '0;
      tc_q       <= '0;
      nc_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      tc_q       <= tc_d;
      nc_q       <= nc_d;
      overflow_q <= flush_i ? 1'b0 : (overflow_q | (any_valid && !fifo_ready));
    end
  end

  assign ready_o        = fifo_ready;
  assign overflow_o     = overflow_q;
  assign lc_uop_entry_o = lc_q;
  assign tc_uop_entry_o = tc_q;
  assign nc_uop_entry_o = nc_q;

endmodule
